// File: rtl/pipe_skid_reg_pkg.sv
// ============================================================================
// Module   : pipe_skid_reg_pkg
// Purpose  : Shared constants and state encoding for the skid pipeline register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_skid_reg_pkg;

    localparam logic        ZeroBit  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Stall encoding seen by a stage: Stop holds it, NoStop lets it advance.
    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage : pipe_skid_reg_pkg

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module   : pipe_slot
// Purpose  : One payload register with valid flag; clear beats load beats drop
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Drop only retires the entry; the payload register keeps its value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= ZeroBit;
            r_data  <= '0;
        end else if (clear) begin
            r_valid <= ZeroBit;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (drop) begin
            r_valid <= ZeroBit;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule : pipe_slot

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module   : pipe_skid_reg
// Purpose  : Valid/ready pipeline register with optional skid entry and flush
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int SKID_EN = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    state_e            r_state;
    logic              r_in_ready;
    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_main_valid;
    logic [DATA_W-1:0] w_main_data;
    logic              w_main_load;
    logic              w_main_drop;
    logic [DATA_W-1:0] w_main_load_data;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;

    assign w_xfer_in  = in_valid && in_ready;
    assign w_xfer_out = w_main_valid && out_ready;

    // r_in_ready is "count<2 after the last edge" with a skid entry; without
    // one it only marks that reset has been left, the rest is combinational.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= EMPTY;
            r_in_ready <= ZeroBit;
        end else if (flush) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_xfer_in) r_state <= ONE;
                    r_in_ready <= 1'b1;
                end
                ONE: begin
                    if (w_xfer_in && !w_xfer_out) begin
                        r_state    <= FULL;
                        r_in_ready <= ZeroBit;
                    end else begin
                        if (w_xfer_out && !w_xfer_in) r_state <= EMPTY;
                        r_in_ready <= 1'b1;
                    end
                end
                FULL: begin
                    if (w_xfer_out) begin
                        r_state    <= ONE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_in_ready <= ZeroBit;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign w_main_load = ((r_state == EMPTY) && w_xfer_in)
                      || ((r_state == ONE)   && w_xfer_in && w_xfer_out)
                      || ((r_state == FULL)  && w_xfer_out);
    assign w_main_drop = (r_state == ONE) && w_xfer_out && !w_xfer_in;
    assign w_main_load_data = (r_state == FULL) ? w_skid_data : in_data;

    pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .load      (w_main_load),
        .drop      (w_main_drop),
        .load_data (w_main_load_data),
        .valid     (w_main_valid),
        .data      (w_main_data)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            logic w_skid_load;
            logic w_skid_drop;

            assign w_skid_load = (r_state == ONE)  && w_xfer_in && !w_xfer_out;
            assign w_skid_drop = (r_state == FULL) && w_xfer_out;

            pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk       (clk),
                .resetn    (resetn),
                .clear     (flush),
                .load      (w_skid_load),
                .drop      (w_skid_drop),
                .load_data (in_data),
                .valid     (w_skid_valid),
                .data      (w_skid_data)
            );

            assign in_ready = r_in_ready && !flush;
        end else begin : g_no_skid
            assign w_skid_valid = ZeroBit;
            assign w_skid_data  = '0;
            assign in_ready     = r_in_ready && !flush && (!w_main_valid || out_ready);
        end
    endgenerate

    assign out_valid = w_main_valid;
    assign out_data  = w_main_valid ? w_main_data : '0;
    assign count     = r_state;

endmodule : pipe_skid_reg

`default_nettype wire
